cpu_player: RTL and testbench

//  Computer opponent for tug-of-war. Drives the game in place of a human

---
 rtl/tow_pkg.sv | 21 ++
 rtl/cpu_player_if.sv | 15 +
 rtl/cpu_player_lfsr10.sv | 30 +++
 rtl/cpu_player.sv | 136 +++++++++++++
 tb/tb_cpu_player.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war computer opponent.
// The LFSR taps are fixed for the 10-bit polynomial x^10 + x^7 + 1.
package tow_pkg;

  typedef enum logic [1:0] {WAIT, FIRE, HOLD, COOL} cpu_state_t;

  localparam int             LFSR_LEN  = 10;
  localparam logic [9:0]     LFSR_SEED = 10'h001;
  localparam int             TAP_HI    = 9;
  localparam int             TAP_LO    = 6;

  // Counter width for a count of n: $clog2(n), never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [LFSR_LEN-1:0] lfsr_next(input logic [LFSR_LEN-1:0] s);
    return {s[LFSR_LEN-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/cpu_player_if.sv
// Control and key-emulation signals between the game logic and the
// computer opponent.
interface cpu_player_if #(
  parameter int DIFF_W = 9
);
  logic              enable;
  logic              clear;
  logic [DIFF_W-1:0] difficulty;
  logic              press;
  logic              key_n;
  logic              busy;

  modport master (output enable, clear, difficulty, input press, key_n, busy);
  modport slave  (input enable, clear, difficulty, output press, key_n, busy);
endinterface

// File: rtl/cpu_player_lfsr10.sv
// 10-bit Fibonacci LFSR that advances on step and self-heals from the
// all-zero lock-up state.
module lfsr10
  import tow_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                step,
  output logic [LFSR_LEN-1:0] q
);

  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_q == '0) begin
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: on each decision tick compares the LFSR against the
// difficulty and, on a hit, emits a press pulse plus an emulated key hold.
module cpu_player
  import tow_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000 / 16,
  parameter int HOLD_CYC   = 1_000_000,
  parameter int COOL_TICKS = 1,
  parameter int LFSR_W     = 10,
  parameter int DIFF_W     = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  cpu_player_if.slave  bus
);

  localparam int TW = cnt_w(TICK_DIV);
  localparam int HW = cnt_w(HOLD_CYC);
  localparam int CW = cnt_w(COOL_TICKS);

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'((HOLD_CYC > 1) ? HOLD_CYC - 2 : 0);
  localparam logic [CW-1:0]     COOL_LAST = CW'((COOL_TICKS > 0) ? COOL_TICKS - 1 : 0);
  localparam logic [LFSR_W-1:0] DIFF_MASK = LFSR_W'((1 << DIFF_W) - 1);

  cpu_state_t        state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]     cool_cnt_q, cool_cnt_d;
  logic              press_q, press_d;
  logic              key_n_q, key_n_d;
  logic              busy_q, busy_d;

  logic              run;
  logic              tick;
  logic              hit;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;

  lfsr10 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (lfsr_step),
    .q       (lfsr_q)
  );

  // NOTE: every variable gets a default at the top of the block, so no
  // path through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    // The tick counter also runs while a press sequence is in flight, so
    // dropping enable mid-press still lets COOL finish.
    run        = bus.enable | (state_q != WAIT);
    tick       = run && (tick_cnt_q == TICK_LAST);
    hit        = tick && ((lfsr_q & DIFF_MASK) < LFSR_W'(bus.difficulty));
    lfsr_step  = tick && !bus.clear;

    tick_cnt_d = tick_cnt_q;
    if (run) tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cool_cnt_d = cool_cnt_q;

    case (state_q)
      WAIT: begin
        if (hit && bus.enable) state_d = FIRE;
      end
      FIRE: begin
        hold_cnt_d = '0;
        if (HOLD_CYC > 1)        state_d = HOLD;
        else if (COOL_TICKS > 0) state_d = COOL;
        else                     state_d = WAIT;
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (COOL_TICKS > 0) state_d = COOL;
          else                state_d = WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      COOL: begin
        // Hits landing here are deliberately dropped; only ticks are counted.
        if (tick) begin
          if (cool_cnt_q == COOL_LAST) begin
            cool_cnt_d = '0;
            state_d    = WAIT;
          end else begin
            cool_cnt_d = cool_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT;
    endcase

    if (bus.clear) begin
      state_d    = WAIT;
      tick_cnt_d = '0;
      hold_cnt_d = '0;
      cool_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they come straight off flops.
    press_d = (state_d == FIRE);
    key_n_d = !((state_d == FIRE) || (state_d == HOLD));
    busy_d  = (state_d != WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      cool_cnt_q <= '0;
      press_q    <= 1'b0;
      key_n_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      press_q    <= press_d;
      key_n_q    <= key_n_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.press = press_q;
  assign bus.key_n = key_n_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: randomized control inputs checked
// cycle by cycle against a timeline-based behavioural model.
module tb_cpu_player;
  import tow_pkg::*;

  localparam int TD = 4;
  localparam int HC = 3;
  localparam int CT = 1;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  cpu_player_if #(.DIFF_W(DW)) bus ();

  cpu_player #(
    .TICK_DIV(TD), .HOLD_CYC(HC), .COOL_TICKS(CT), .LFSR_W(10), .DIFF_W(DW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: presses are kept as a start cycle on a timeline; key_n is low
  // for the HC cycles from that start, then CT ticks of cool-down follow.
  int m_cyc, m_ps, m_cool, m_tcnt, m_lfsr;
  int n_press, last_press;

  function automatic bit m_window();
    return (m_cyc >= m_ps) && (m_cyc - m_ps < HC);
  endfunction

  function automatic bit m_busy();
    return m_window() || (m_cool > 0);
  endfunction

  function automatic bit m_hit_pending();
    return !m_busy() && bus.enable && !bus.clear && (m_tcnt == TD - 1) &&
           ((m_lfsr % 512) < int'(bus.difficulty));
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ps = -1000; m_cool = 0; m_tcnt = 0; m_lfsr = 1;
    last_press = -1;
  endtask

  task automatic model_edge();
    bit busy_now, win, run, tick, hit;
    if (!reset_n) begin
      model_reset();
      return;
    end
    busy_now = m_busy();
    win      = m_window();
    if (bus.clear) begin
      m_tcnt = 0; m_ps = -1000; m_cool = 0; last_press = -1;
      m_cyc++;
      return;
    end
    run  = bus.enable || busy_now;
    tick = run && (m_tcnt == TD - 1);
    hit  = tick && ((m_lfsr % 512) < int'(bus.difficulty));
    if (run)  m_tcnt = (m_tcnt + 1) % TD;
    if (tick) m_lfsr = ((m_lfsr << 1) & 'h3FF) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
    if (!busy_now) begin
      if (hit && bus.enable) m_ps = m_cyc + 1;
    end else if (win) begin
      if (m_cyc - m_ps == HC - 1) m_cool = CT;
    end else if (tick) begin
      m_cool--;
    end
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("press", bus.press, (m_cyc == m_ps));
    check("key_n", bus.key_n, !m_window());
    check("busy",  bus.busy,  m_busy());
    check("lfsr",  dut.lfsr_q, m_lfsr);
    if (bus.press === 1'b1) begin
      if (last_press >= 0) check("spacing", (m_cyc - last_press) >= HC + CT * TD, 1);
      last_press = m_cyc;
      n_press++;
    end
  endtask

  task automatic first_press_after_reset(input string tag);
    int first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.press === 1'b1 && first == 0) first = i;
    end
    check(tag, first, 4);
  endtask

  task automatic find_hold(input string tag);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (bus.press === 1'b0 && bus.key_n === 1'b0) found = 1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    bus.enable = 1'b0; bus.clear = 1'b0; bus.difficulty = '0;
    n_press = 0;
    model_reset();
    #1 reset_n = 1'b0;

    // Reset, then idle with enable low.
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();
    check("idle_presses", n_press, 0);

    // Threshold: all-ones fires on the first tick, then zero never fires.
    bus.enable = 1'b1; bus.difficulty = 9'h1FF;
    first_press_after_reset("first_press");
    bus.difficulty = '0;
    repeat (20) step();
    n_press = 0;
    repeat (200) step();
    check("diff0_presses", n_press, 0);

    // Long LFSR run at mid difficulty.
    bus.difficulty = 9'h100;
    repeat (1023 * TD) step();

    // Clear during HOLD.
    bus.difficulty = 9'h1FF;
    find_hold("find_hold_clear");
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clear_key_n", bus.key_n, 1);
    check("clear_busy",  bus.busy,  0);
    check("clear_state", dut.state_q, WAIT);

    // Clear on a hit cycle suppresses the press.
    begin
      bit found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        if (m_hit_pending()) found = 1;
        else step();
      end
      check("find_hit", found, 1);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      check("clear_hit_press", bus.press, 0);
    end

    // Async reset mid-HOLD, between clock edges.
    find_hold("find_hold_reset");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_key_n", bus.key_n, 1);
    check("rst_press", bus.press, 0);
    check("rst_busy",  bus.busy,  0);
    n_press = 0;
    repeat (5) step();
    check("rst_no_press", n_press, 0);
    reset_n = 1'b1;
    first_press_after_reset("first_press_after_rst");

    // Randomized control traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.clear  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.difficulty = '0;
          1:       bus.difficulty = 9'h1FF;
          default: bus.difficulty = DW'($urandom);
        endcase
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rand_rst_key_n", bus.key_n, 1);
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
